// File: rtl/arm1_prog_loader.sv
// arm1_prog_loader: streams a fixed-length program into processor memory,
// optionally verifies a trailing 8-bit additive checksum, and holds the
// processor in reset until a load has completed with a good checksum.
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on the registered state, never on
// in_valid. in_valid while in_ready is 0 is ignored, and the source may drop
// in_valid at any time without penalty.
module arm1_prog_loader #(
    parameter int PROG_LEN = 16,
    parameter int CHK_EN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] byte_count,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    // Index of the final program byte; the transfer at this count ends LOAD.
    localparam logic [4:0] LAST_IDX = 5'(PROG_LEN - 1);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_count;
    logic [7:0] r_sum;
    logic       r_mem_we;
    logic [3:0] r_mem_addr;
    logic [7:0] r_mem_wdata;

    logic w_ready;
    logic w_xfer;
    logic w_last;
    logic w_start_load;

    assign w_ready      = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_xfer       = in_valid && w_ready;
    assign w_last       = (r_count == LAST_IDX);
    assign w_start_load = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERROR));

    // State register; reset returns to IDLE with the processor held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and state-decoded status outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_start_load) w_next = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer && w_last) begin
                    w_next = (CHK_EN != 0) ? S_CHECK : S_DONE;
                end
            end
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_xfer) begin
                    w_next = (in_data == r_sum) ? S_DONE : S_ERROR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (w_start_load) w_next = S_LOAD;
            end
            S_ERROR: begin
                error = 1'b1;
                if (w_start_load) w_next = S_LOAD;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: byte counter, running sum and the one-cycle-delayed memory
    // write port. The checksum byte in CHECK never reaches the write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count     <= 5'd0;
            r_sum       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 4'd0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_load) begin
                r_count <= 5'd0;
                r_sum   <= 8'd0;
            end else if ((r_state == S_LOAD) && w_xfer) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_count[3:0];
                r_mem_wdata <= in_data;
                r_count     <= r_count + 5'd1;
                r_sum       <= r_sum + in_data;
            end
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign byte_count = r_count;
    assign dbg_state  = r_state;

endmodule

// File: doc/arm1_prog_loader.md
ARM1_PROG_LOADER -- requirements
Module: arm1_prog_loader

Interface
REQ-001 SHALL have parameter PROG_LEN, default 16, the number of program bytes per load (legal 1..16).
REQ-002 SHALL have parameter CHK_EN, default 1, which when 1 makes a trailing checksum byte follow the program bytes.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port in_valid  input  1  source has a byte on in_data.
REQ-007 SHALL have port in_data  input  8  program or checksum byte.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  write strobe to processor memory.
REQ-010 SHALL have port mem_addr  output  4  write address.
REQ-011 SHALL have port mem_wdata  output  8  write data.
REQ-012 SHALL have port cpu_reset  output  1  active-high hold for the processor's reset.
REQ-013 SHALL have port busy  output  1  high in LOAD and CHECK.
REQ-014 SHALL have port done  output  1  load completed with a good checksum.
REQ-015 SHALL have port error  output  1  checksum mismatch.
REQ-016 SHALL have port byte_count  output  5  program bytes accepted in the current load.

Function
REQ-017 SHALL implement the states IDLE, LOAD, CHECK, DONE and ERROR.
REQ-018 A byte SHALL transfer only in a cycle where in_valid=1 and in_ready=1; in_valid without in_ready SHALL have no effect.
REQ-019 in_ready SHALL be 1 only in LOAD and CHECK.
REQ-020 In IDLE, DONE or ERROR, start=1 SHALL move to LOAD next cycle and clear byte_count and the running sum; cpu_reset SHALL be 1 from that cycle.
REQ-021 start SHALL be ignored in LOAD and CHECK.
REQ-022 In LOAD, each transfer SHALL register mem_we=1, mem_addr=byte_count[3:0] and mem_wdata=in_data for exactly the following cycle (1-cycle latency).
REQ-023 In LOAD, each transfer SHALL increment byte_count and add in_data to an 8-bit sum, wrapping modulo 256.
REQ-024 mem_we SHALL be 0 in every cycle not immediately following a LOAD transfer; mem_addr and mem_wdata SHALL hold their last values.
REQ-025 On the PROG_LEN-th transfer, the state SHALL move to CHECK if CHK_EN=1, else to DONE.
REQ-026 In CHECK, the transfer SHALL compare in_data with the sum: equal moves to DONE, unequal moves to ERROR; the checksum byte SHALL NOT be written to memory.
REQ-027 In DONE: done=1, cpu_reset=0, error=0.
REQ-028 In ERROR: error=1, cpu_reset=1, done=0.
REQ-029 done and error SHALL clear in the cycle the state leaves DONE or ERROR.
REQ-030 Addresses at or above PROG_LEN SHALL never be written.
REQ-031 byte_count SHALL hold its final value in DONE and ERROR.

Reset
REQ-032 When reset=0 at a clock edge, the next state SHALL be: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, byte_count=0, sum=0.
REQ-033 Reset asserted mid-load SHALL abort the load; no mem_we SHALL occur in the cycle after the reset edge; the processor stays held in reset.

Verification
REQ-034 Defaults; start, then bytes 0x00..0x0F, then 0x78 -> 16 writes addr i/data i, each one cycle after its handshake; then done=1, cpu_reset=0, byte_count=16.
REQ-035 Same program with checksum 0x77 -> error=1, done=0, cpu_reset=1, no write of 0x77.
REQ-036 in_valid toggled 1/0 every cycle during load -> writes only after handshakes, contents identical to REQ-034, done=1.
REQ-037 reset=0 for 1 cycle after 5 program bytes -> IDLE, byte_count=0, cpu_reset=1, no further writes, and extra in_valid bytes ignored.
REQ-038 start pulsed during LOAD -> ignored; start from DONE -> cpu_reset=1 next cycle, done=0, new load writes from addr 0.
REQ-039 PROG_LEN=4, CHK_EN=0; bytes 0xCE,0xDF,0x00,0xFF -> 4 writes to addresses 0..3, then DONE, and addr 4..15 are never written.
